// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: IMEM address/data, execute redirect, and the
// valid/ready handshake toward decode.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_insn;
    logic        out_fault;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_insn,
        output out_fault
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_insn,
        input  out_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a zero-latency IMEM and holds one
// fetch/decode entry behind a valid/ready handshake; faults halt fetching until redirected.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IMEM_BYTES = 32'd1024
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_stage_if.master    bus,
    output logic [31:0]      fetch_count
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        valid_q, valid_n;
    logic [31:0] opc_q, opc_n;
    logic [31:0] insn_q, insn_n;
    logic        fault_q, fault_n;
    logic        fault_cond;
    logic        slot_free;
    logic        advance;
    logic        transfer;

    assign bus.imem_addr = pc;
    assign bus.out_valid = valid_q;
    assign bus.out_pc    = opc_q;
    assign bus.out_insn  = insn_q;
    assign bus.out_fault = fault_q;

    assign fault_cond = (pc[1:0] != 2'b00) || (pc >= IMEM_BYTES);
    assign slot_free  = !valid_q || bus.out_ready;
    assign advance    = slot_free && (state == RUN) && !bus.redirect_valid;
    assign transfer   = valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            valid_q     <= 1'b0;
            opc_q       <= '0;
            insn_q      <= '0;
            fault_q     <= 1'b0;
            fetch_count <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            valid_q <= valid_n;
            opc_q   <= opc_n;
            insn_q  <= insn_n;
            fault_q <= fault_n;
            // A redirect flushes the entry but the handshake itself still completes
            if (transfer) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = valid_q;
        opc_n   = opc_q;
        insn_n  = insn_q;
        fault_n = fault_q;

        if (bus.redirect_valid) begin
            pc_n    = bus.redirect_pc;
            state_n = RUN;
            valid_n = 1'b0;
        end else if (advance) begin
            valid_n = 1'b1;
            opc_n   = pc;
            if (fault_cond) begin
                insn_n  = '0;
                fault_n = 1'b1;
                state_n = HALT;
            end else begin
                insn_n  = bus.imem_data;
                fault_n = 1'b0;
                pc_n    = pc + 32'd4;
            end
        end else if (slot_free) begin
            // Only reachable in HALT: drain the held entry and stop presenting
            valid_n = 1'b0;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the instruction memory. It holds the program counter and drives the IMEM word address. It captures the combinational read data into a fetch/decode pipeline register and presents it to decode over a valid/ready handshake. It also handles control-flow redirects and raises a fault for misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_BYTES, 1024: IMEM size in bytes. A fetch with pc >= IMEM_BYTES is out of range.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  32  byte address to IMEM; combinationally equal to pc.
- imem_data  input  32  combinational IMEM read data for imem_addr.
- redirect_valid  input  1  control-flow redirect from execute.
- redirect_pc  input  32  redirect target.
- out_valid  output  1  fetch/decode register holds an entry.
- out_ready  input  1  decode accepts the entry.
- out_pc  output  32  PC of the held entry.
- out_insn  output  32  instruction of the held entry; 0 when out_fault=1.
- out_fault  output  1  held entry is a fetch fault.
- fetch_count  output  32  number of entries accepted by decode; wraps mod 2^32.

Behaviour:
- Reset, asynchronous and active-low:
  - pc = RESET_PC, state = RUN.
  - out_valid = 0, out_pc = 0, out_insn = 0, out_fault = 0, fetch_count = 0.
- imem_addr = pc at all times. IMEM read is zero-latency, so an entry is captured in the same cycle its address is driven.
- fault_cond = (pc[1:0] != 0) OR (pc >= IMEM_BYTES), using an unsigned 32-bit compare.
- Define slot_free = !out_valid OR out_ready.
- Define advance = slot_free AND state==RUN AND !redirect_valid.
- States:
  - RUN: normal fetch.
  - HALT: a fault entry has been issued; no fetching.
- Per cycle, in priority order:
  1. redirect_valid=1 (any state):
     - pc <= redirect_pc; state <= RUN; out_valid <= 0.
     - The held entry is flushed even if out_ready=1 this cycle. The handshake still completes and counts toward fetch_count, but nothing new is captured.
  2. advance AND !fault_cond:
     - out_valid <= 1, out_pc <= pc, out_insn <= imem_data, out_fault <= 0.
     - pc <= pc + 4 (32-bit wrap).
  3. advance AND fault_cond:
     - out_valid <= 1, out_pc <= pc, out_insn <= 0, out_fault <= 1.
     - pc holds; state <= HALT.
  4. slot_free in HALT without redirect: out_valid <= 0 once any held entry drains; pc holds.
  5. Otherwise, stall (out_valid=1, out_ready=0): all out_* and pc hold.
- Handshake:
  - An entry transfers when out_valid AND out_ready at the clock edge.
  - out_* must not change while out_valid=1 and out_ready=0.
  - out_valid does not depend combinationally on out_ready.
- fetch_count increments by 1 on every transfer, including fault entries and entries transferring in a redirect cycle.
- Throughput is one entry per cycle with out_ready held high. Latency from redirect to the first new out_valid is 2 cycles: redirect at edge N, capture at edge N+1.
- Reset mid-operation returns everything to reset values immediately; no entry survives.

Test Plan:
1. Reset with RESET_PC=0, IMEM words 0..3 = 0x11, 0x22, 0x33, 0x44, out_ready=1:
   - After reset release, the bench sees (pc, insn) = (0, 0x11), (4, 0x22), (8, 0x33), (0xC, 0x44) on consecutive cycles.
   - fetch_count reaches 4.
2. Backpressure: out_ready=0 for 3 cycles while holding (4, 0x22):
   - out_* stable and pc = 8 throughout.
   - On release, (4, 0x22) is followed by (8, 0x33) with no skip or duplicate.
3. Redirect to 0x40 while (8, 0x33) is held and out_ready=0:
   - Next cycle out_valid=0.
   - The following cycle yields (0x40, mem[16]).
   - The entry at pc 8 is never delivered.
4. Misaligned redirect to 0x42:
   - One entry (0x42, insn 0, fault 1) is delivered, then out_valid stays 0 and pc stays 0x42.
   - A redirect to 0x0 resumes with (0, 0x11).
5. Out of range, sequential fetch reaching pc=0x3FC then 0x400:
   - (0x3FC, mem[255]) is delivered normally.
   - Then (0x400, 0, fault=1) is delivered and the stage enters HALT.
6. Asynchronous reset asserted mid-stream (between edges):
   - out_valid, out_fault and fetch_count drop to 0 immediately; pc = RESET_PC.
